fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the program counter and sequences the word-addressed instruction memory. It presents the PC as the IMEM read address and captures the returned instruction into an IF/ID output register. It delivers each instruction to decode through a valid/ready handshake. It also handles start, stall, redirect (branch/jump), halt-opcode detection and out-of-range faults.

---
 rtl/fetch_sequencer.sv | 108 ++++++++++
 tb/tb_fetch_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the word-addressed PC, drives IMEM and
// delivers fetched instructions to decode via an IF/ID valid/ready register.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int unsigned IMEM_DEPTH  = 16,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [1:0]  state,
    output logic        halted,
    output logic        fault
);

    localparam int unsigned PC_W    = 32;
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [PC_W-1:0]   opc_q, opc_d;
    logic              accept_c;
    logic              is_halt_c;

    assign accept_c  = !valid_q || out_ready;
    assign is_halt_c = (imem_instr[OPC_MSB:OPC_LSB] == HALT_OPCODE);

    // State and IF/ID register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            instr_q   <= 32'd0;
            opc_q     <= 32'd0;
            halted    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            opc_q     <= opc_d;
            halted    <= (state_d == ST_HALT);
            fault     <= (state_d == ST_FAULT);
        end
    end

    // Next-state and fetch decisions; redirect beats fault beats capture
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (accept_c) begin
                    if (pc_q >= PC_W'(IMEM_DEPTH)) begin
                        state_d = ST_FAULT;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = imem_instr;
                        opc_d   = pc_q;
                        valid_d = 1'b1;
                        if (is_halt_c) state_d = ST_HALT;
                        else           pc_d    = pc_q + PC_W'(1);
                    end
                end
            end
            default: begin
                // HALT/FAULT only drain the pending output
                if (out_ready) valid_d = 1'b0;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = opc_q;
    assign state     = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed plan steps then randomized episodes,
// every cycle compared against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

    localparam int unsigned DEPTH   = 16;
    localparam logic [5:0]  HALT_OP = 6'b111111;
    localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_FAULT = 3;

    logic        clk = 1'b0;
    logic        reset, start, redirect_valid, out_ready;
    logic [31:0] imem_addr, imem_instr, redirect_pc;
    logic        out_valid, halted, fault;
    logic [31:0] out_instr, out_pc;
    logic [1:0]  state;

    logic [31:0] mem [0:31];

    int          m_st;
    logic [31:0] m_pc, m_instr, m_opc;
    bit          m_valid;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < 32'd32) ? mem[imem_addr[4:0]] : 32'hDEAD_BEEF;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_instr(out_instr), .out_pc(out_pc),
        .state(state), .halted(halted), .fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_pc = 32'd0; m_valid = 1'b0; m_instr = 32'd0; m_opc = 32'd0;
    endtask

    // One clock edge of the fetch rules, applied to the current inputs
    task automatic model_step();
        bit          acc;
        logic [31:0] word;
        acc = !m_valid || out_ready;
        case (m_st)
            S_IDLE: if (start) m_st = S_RUN;
            S_RUN: begin
                if (redirect_valid) begin
                    m_pc = redirect_pc;
                    m_valid = 1'b0;
                end else if (acc) begin
                    if (m_pc >= 32'(DEPTH)) begin
                        m_st = S_FAULT;
                        m_valid = 1'b0;
                    end else begin
                        word    = mem[m_pc[4:0]];
                        m_instr = word;
                        m_opc   = m_pc;
                        m_valid = 1'b1;
                        if (word[31:26] == HALT_OP) m_st = S_HALT;
                        else m_pc = m_pc + 32'd1;
                    end
                end
            end
            default: if (out_ready) m_valid = 1'b0;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},     32'(state),     32'(m_st));
        chk({tag, ".imem_addr"}, imem_addr,      m_pc);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".out_instr"}, out_instr,      m_instr);
        chk({tag, ".out_pc"},    out_pc,         m_opc);
        chk({tag, ".halted"},    32'(halted),    32'(m_st == S_HALT));
        chk({tag, ".fault"},     32'(fault),     32'(m_st == S_FAULT));
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0000_1000 + 32'(i);
        mem[0] = 32'h0022_1820; mem[1] = 32'h2109_000A; mem[2] = 32'h0000_0000; mem[3] = 32'hFC00_0000;

        // Straight-line run into HALT
        do_reset();
        start = 1'b1; out_ready = 1'b1;
        cycle("start");
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle("run");
            chk("seq_pc", out_pc, 32'(k));
            chk("seq_valid", 32'(out_valid), 32'd1);
        end
        chk("halt_state", 32'(state), 32'd2);
        chk("halt_flag", 32'(halted), 32'd1);
        cycle("drain");
        chk("halt_pc_hold", imem_addr, 32'd3);
        chk("halt_drained", 32'(out_valid), 32'd0);
        start = 1'b1; redirect_valid = 1'b1;
        cycle("start_in_halt");
        start = 1'b0; redirect_valid = 1'b0;
        chk("halt_ignores", imem_addr, 32'd3);

        // Stall holds output and PC
        mem[3] = 32'h1234_5678;
        do_reset();
        start = 1'b1;
        cycle("start2");
        start = 1'b0;
        cycle("cap0");
        for (int k = 0; k < 3; k++) begin
            cycle("stall");
            chk("stall_pc", out_pc, 32'd0);
            chk("stall_instr", out_instr, 32'h0022_1820);
            chk("stall_addr", imem_addr, 32'd1);
        end
        out_ready = 1'b1;
        cycle("release");
        chk("release_pc", out_pc, 32'd1);

        // Redirect flush, then start in RUN is ignored
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        cycle("redirect");
        chk("flush_valid", 32'(out_valid), 32'd0);
        redirect_valid = 1'b0;
        cycle("after_redirect");
        chk("redir_pc", out_pc, 32'd0);
        start = 1'b1;
        cycle("start_in_run");
        start = 1'b0;

        // Out-of-range redirect target faults on the next accepted fetch
        redirect_valid = 1'b1; redirect_pc = 32'd20;
        cycle("redirect_oor");
        redirect_valid = 1'b0;
        cycle("fault");
        chk("fault_flag", 32'(fault), 32'd1);
        chk("fault_valid", 32'(out_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        cycle("fault_ignores");
        redirect_valid = 1'b0;
        chk("fault_pc_hold", imem_addr, 32'd20);

        // Asynchronous reset mid-run
        do_reset();
        start = 1'b1; out_ready = 1'b1;
        cycle("start3");
        start = 1'b0;
        repeat (2) cycle("run3");
        chk("pre_reset_addr", imem_addr, 32'd2);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        reset = 1'b0;
        repeat (3) cycle("idle_wait");
        chk("idle_no_fetch", imem_addr, 32'd0);

        // Randomized episodes
        for (int ep = 0; ep < 8; ep++) begin
            for (int i = 0; i < 32; i++) begin
                logic [31:0] w;
                w = $urandom;
                if (w[31:26] == HALT_OP) w[31] = 1'b0;
                if ($urandom_range(0, 19) == 0) w[31:26] = HALT_OP;
                mem[i] = w;
            end
            do_reset();
            for (int c = 0; c < 150; c++) begin
                start          = ($urandom_range(0, 9) == 0);
                out_ready      = ($urandom_range(0, 3) != 0);
                redirect_valid = ($urandom_range(0, 11) == 0);
                redirect_pc    = 32'($urandom_range(0, 19));
                cycle("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
